frame_demux1_2: RTL and testbench

AXIS 1-to-2 frame demultiplexer placed directly upstream of the interleaver's 2:1 AXIS mux (ping-pong path). It steers whole frames alternately to branch 0 and branch 1, starting with branch 0. Frame boundaries come from input tlast or from a fixed frame length. It also drives the registered `sel` that tells the downstream mux which branch holds the oldest unfinished frame. The block provides full-throughput registered outputs through a one-entry skid buffer.

---
 rtl/frame_demux1_2_pkg.sv | 9 +
 rtl/frame_demux1_2_skid.sv | 108 ++++++++++
 rtl/frame_demux1_2.sv | 97 +++++++++
 tb/tb_frame_demux1_2.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_demux1_2_pkg.sv
// Shared helpers for the frame_demux1_2 ping-pong frame splitter.
package frame_demux1_2_pkg;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_demux1_2_skid.sv
// Main + skid register slice carrying {data, last, dest}; ready is registered
// so the downstream ready never reaches the upstream ready combinationally.
module axis_skid_reg
    import frame_demux1_2_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_data,
    input  logic         i_last,
    input  logic         i_dest,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_last,
    output logic         o_dest,
    output logic         o_valid,
    input  logic         i_ready
);

    logic [W-1:0] r_main_data;
    logic         r_main_last;
    logic         r_main_dest;
    logic         r_main_valid;
    logic [W-1:0] r_skid_data;
    logic         r_skid_last;
    logic         r_skid_dest;
    logic         r_skid_valid;
    logic         r_ready;

    logic w_in_hs;
    logic w_out_hs;
    logic w_main_from_in;
    logic w_main_from_skid;
    logic w_skid_load;
    logic w_main_valid_nx;
    logic w_skid_valid_nx;

    assign w_in_hs  = i_valid && r_ready;
    assign w_out_hs = r_main_valid && i_ready;

    always_comb begin
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_main_valid_nx  = r_main_valid;
        w_skid_valid_nx  = r_skid_valid;
        if (!r_main_valid) begin
            if (w_in_hs) begin
                w_main_from_in  = 1'b1;
                w_main_valid_nx = 1'b1;
            end
        end else if (w_out_hs) begin
            // Skid is older than any new input, so it always goes first.
            if (r_skid_valid) begin
                w_main_from_skid = 1'b1;
                w_skid_valid_nx  = 1'b0;
            end else if (w_in_hs) begin
                w_main_from_in = 1'b1;
            end else begin
                w_main_valid_nx = 1'b0;
            end
        end else if (w_in_hs) begin
            w_skid_load     = 1'b1;
            w_skid_valid_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data  <= '0;
            r_main_last  <= 1'b0;
            r_main_dest  <= 1'b0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_dest  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_nx;
            r_skid_valid <= w_skid_valid_nx;
            r_ready      <= !w_skid_valid_nx;
            if (w_main_from_in) begin
                r_main_data <= i_data;
                r_main_last <= i_last;
                r_main_dest <= i_dest;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
                r_main_last <= r_skid_last;
                r_main_dest <= r_skid_dest;
            end
            if (w_skid_load) begin
                r_skid_data <= i_data;
                r_skid_last <= i_last;
                r_skid_dest <= i_dest;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_data  = r_main_data;
    assign o_last  = r_main_last;
    assign o_dest  = r_main_dest;
    assign o_valid = r_main_valid;

endmodule

// File: rtl/frame_demux1_2.sv
// AXIS 1:2 frame demux: whole frames alternate m0/m1, with a registered sel
// naming the branch that holds the oldest undelivered frame.
module frame_demux1_2
    import frame_demux1_2_pkg::*;
#(
    parameter int width     = 1,
    parameter int frame_len = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [width-1:0] m0_axis_tdata,
    output logic             m0_axis_tvalid,
    output logic             m0_axis_tlast,
    input  logic             m0_axis_tready,
    output logic [width-1:0] m1_axis_tdata,
    output logic             m1_axis_tvalid,
    output logic             m1_axis_tlast,
    input  logic             m1_axis_tready,
    output logic             sel
);

    localparam int            CW       = cnt_width(frame_len);
    localparam logic [CW-1:0] LAST_CNT = CW'(frame_len - 1);

    logic          r_wdest;
    logic          r_sel;
    logic [CW-1:0] r_beat_cnt;

    logic             w_s_ready;
    logic             w_in_hs;
    logic             w_eff_last;
    logic [width-1:0] w_main_data;
    logic             w_main_last;
    logic             w_main_dest;
    logic             w_main_valid;
    logic             w_br_ready;
    logic             w_out_hs;

    assign w_in_hs    = s_axis_tvalid && w_s_ready;
    assign w_eff_last = (frame_len == 0) ? s_axis_tlast
                                         : (r_beat_cnt == LAST_CNT);

    assign w_br_ready = w_main_dest ? m1_axis_tready : m0_axis_tready;
    assign w_out_hs   = w_main_valid && w_br_ready;

    axis_skid_reg #(
        .W (width)
    ) u_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (s_axis_tdata),
        .i_last  (w_eff_last),
        .i_dest  (r_wdest),
        .i_valid (s_axis_tvalid),
        .o_ready (w_s_ready),
        .o_data  (w_main_data),
        .o_last  (w_main_last),
        .o_dest  (w_main_dest),
        .o_valid (w_main_valid),
        .i_ready (w_br_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdest    <= 1'b0;
            r_beat_cnt <= '0;
            r_sel      <= 1'b0;
        end else begin
            if (w_in_hs) begin
                if (w_eff_last) begin
                    r_wdest    <= ~r_wdest;
                    r_beat_cnt <= '0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + CW'(1);
                end
            end
            // Oldest frame finished leaving: the consumer moves to the other side.
            if (w_out_hs && w_main_last) begin
                r_sel <= ~r_sel;
            end
        end
    end

    assign s_axis_tready  = w_s_ready;
    assign m0_axis_tdata  = w_main_data;
    assign m1_axis_tdata  = w_main_data;
    assign m0_axis_tlast  = w_main_last;
    assign m1_axis_tlast  = w_main_last;
    assign m0_axis_tvalid = w_main_valid && !w_main_dest;
    assign m1_axis_tvalid = w_main_valid && w_main_dest;
    assign sel            = r_sel;

endmodule

// File: tb/tb_frame_demux1_2.sv
// Bench for frame_demux1_2: two instances (tlast framing and fixed length 5)
// checked every cycle against a queue model of accepted, undelivered beats.
module tb_frame_demux1_2;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       dest;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data[2];
    logic       s_valid[2];
    logic       s_last[2];
    logic       s_ready[2];
    logic [7:0] m0_data[2];
    logic [7:0] m1_data[2];
    logic       m0_valid[2];
    logic       m1_valid[2];
    logic       m0_last[2];
    logic       m1_last[2];
    logic       r0[2];
    logic       r1[2];
    logic       sel[2];

    beat_t q[2][$];
    int    fin[2];
    int    fout[2];
    int    nacc[2];
    int    peak[2];
    bit    armed[2];
    bit    acc[2];
    int    cyc = 0;
    int    ncmp = 0;
    int    nfail = 0;
    int    stall_lo = -1;
    int    stall_hi = -1;

    always #5 clk = ~clk;

    frame_demux1_2 #(.width(8), .frame_len(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_data[0]), .s_axis_tvalid(s_valid[0]),
        .s_axis_tlast(s_last[0]), .s_axis_tready(s_ready[0]),
        .m0_axis_tdata(m0_data[0]), .m0_axis_tvalid(m0_valid[0]),
        .m0_axis_tlast(m0_last[0]), .m0_axis_tready(r0[0]),
        .m1_axis_tdata(m1_data[0]), .m1_axis_tvalid(m1_valid[0]),
        .m1_axis_tlast(m1_last[0]), .m1_axis_tready(r1[0]),
        .sel(sel[0])
    );

    frame_demux1_2 #(.width(8), .frame_len(5)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_data[1]), .s_axis_tvalid(s_valid[1]),
        .s_axis_tlast(s_last[1]), .s_axis_tready(s_ready[1]),
        .m0_axis_tdata(m0_data[1]), .m0_axis_tvalid(m0_valid[1]),
        .m0_axis_tlast(m0_last[1]), .m0_axis_tready(r0[1]),
        .m1_axis_tdata(m1_data[1]), .m1_axis_tvalid(m1_valid[1]),
        .m1_axis_tlast(m1_last[1]), .m1_axis_tready(r1[1]),
        .sel(sel[1])
    );

    task automatic chk(input string tag, input int d,
                       input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, advance the model, then step.
    task automatic cycle();
        bit    er;
        bit    hv;
        bit    ih;
        bit    oh;
        bit    el;
        beat_t hb;
        beat_t nb;
        @(negedge clk);
        if (stall_hi >= 0) r0[0] = !(cyc >= stall_lo && cyc <= stall_hi);
        #1;
        for (int d = 0; d < 2; d++) begin
            acc[d] = 1'b0;
            if (!rst_n) begin
                chk("rst_tready", d, s_ready[d], 0);
                chk("rst_m0_tvalid", d, m0_valid[d], 0);
                chk("rst_m1_tvalid", d, m1_valid[d], 0);
                chk("rst_m0_tdata", d, m0_data[d], 0);
                chk("rst_m1_tdata", d, m1_data[d], 0);
                chk("rst_m0_tlast", d, m0_last[d], 0);
                chk("rst_m1_tlast", d, m1_last[d], 0);
                chk("rst_sel", d, sel[d], 0);
                q[d].delete();
                fin[d] = 0;
                fout[d] = 0;
                nacc[d] = 0;
                armed[d] = 1'b0;
            end else begin
                er = armed[d] && (q[d].size() < 2);
                hv = q[d].size() > 0;
                hb = hv ? q[d][0] : '0;
                chk("s_tready", d, s_ready[d], er);
                chk("m0_tvalid", d, m0_valid[d], hv && !hb.dest);
                chk("m1_tvalid", d, m1_valid[d], hv && hb.dest);
                chk("sel", d, sel[d], fout[d] % 2);
                if (hv) begin
                    chk("m0_tdata", d, m0_data[d], hb.data);
                    chk("m1_tdata", d, m1_data[d], hb.data);
                    chk("m0_tlast", d, m0_last[d], hb.last);
                    chk("m1_tlast", d, m1_last[d], hb.last);
                end
                ih = s_valid[d] && er;
                oh = hv && (hb.dest ? r1[d] : r0[d]);
                if (oh) begin
                    void'(q[d].pop_front());
                    if (hb.last) fout[d]++;
                end
                if (ih) begin
                    el = (d == 0) ? s_last[d] : ((nacc[d] % 5) == 4);
                    nb.data = s_data[d];
                    nb.last = el;
                    nb.dest = fin[d][0];
                    q[d].push_back(nb);
                    nacc[d]++;
                    if (el) fin[d]++;
                    acc[d] = 1'b1;
                end
                if (q[d].size() > peak[d]) peak[d] = q[d].size();
            end
        end
        if (rst_n) begin
            armed[0] = 1'b1;
            armed[1] = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] data, input logic last);
        int n;
        n = 0;
        s_valid[d] = 1'b1;
        s_data[d] = data;
        s_last[d] = last;
        do begin
            cycle();
            n++;
        end while (!acc[d] && n < 40);
        chk("send_accept", d, acc[d], 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int cnt;
        for (int d = 0; d < 2; d++) begin
            s_data[d] = '0;
            s_valid[d] = 1'b0;
            s_last[d] = 1'b0;
            r0[d] = 1'b1;
            r1[d] = 1'b1;
            peak[d] = 0;
        end
        @(posedge clk);
        #1;
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        // Frame alternation on tlast: lengths 4, 1, 3
        for (int i = 0; i < 8; i++)
            send(0, 8'(i), (i == 3) || (i == 4) || (i == 7));
        s_valid[0] = 1'b0;
        repeat (4) cycle();

        // Generated framing every 5 beats, input tlast held low
        for (int i = 0; i < 12; i++) send(1, 8'(i), 1'b0);
        s_valid[1] = 1'b0;
        repeat (4) cycle();

        // Filler so the next frame lands on m0, then backpressure
        send(0, 8'h10, 1'b1);
        peak[0] = 0;
        stall_lo = cyc + 2;
        stall_hi = cyc + 5;
        for (int i = 0; i < 6; i++) send(0, 8'(i), i == 5);
        s_valid[0] = 1'b0;
        repeat (8) cycle();
        stall_hi = -1;
        r0[0] = 1'b1;
        chk("bp_peak", 0, peak[0], 2);

        // Head-of-line: A on stalled m0 blocks B on m1
        send(0, 8'h11, 1'b1);
        s_valid[0] = 1'b0;
        repeat (2) cycle();
        r0[0] = 1'b0;
        send(0, 8'h20, 1'b0);
        send(0, 8'h21, 1'b1);
        s_valid[0] = 1'b1;
        s_data[0] = 8'h30;
        s_last[0] = 1'b0;
        cnt = 0;
        repeat (5) begin
            cycle();
            if (m1_valid[0]) cnt++;
        end
        chk("hol_m1_blocked", 0, cnt, 0);
        r0[0] = 1'b1;
        send(0, 8'h30, 1'b0);
        send(0, 8'h31, 1'b1);
        s_valid[0] = 1'b0;
        repeat (4) cycle();

        // Reset in the middle of a frame headed for m1
        send(0, 8'h12, 1'b1);
        for (int i = 0; i < 3; i++) send(0, 8'(8'h40 + i), 1'b0);
        s_valid[0] = 1'b0;
        cycle();
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        send(0, 8'hA0, 1'b0);
        chk("post_rst_m0_tvalid", 0, m0_valid[0], 1);
        chk("post_rst_m1_tvalid", 0, m1_valid[0], 0);
        chk("post_rst_sel", 0, sel[0], 0);
        chk("post_rst_tdata", 0, m0_data[0], 8'hA0);
        send(0, 8'hA1, 1'b1);
        s_valid[0] = 1'b0;
        repeat (3) cycle();

        // Back-to-back random beats with random tlast
        st = cyc;
        for (int i = 0; i < 64; i++)
            send(0, 8'($urandom), $urandom_range(0, 3) == 0);
        chk("throughput_cycles", 0, cyc - st, 64);
        s_valid[0] = 1'b0;
        repeat (4) cycle();

        // Random valid/ready stress on the fixed-length instance
        for (int i = 0; i < 200; i++) begin
            r0[1] = 1'($urandom_range(0, 1));
            r1[1] = 1'($urandom_range(0, 1));
            if (!s_valid[1] || acc[1]) begin
                s_valid[1] = 1'($urandom_range(0, 1));
                s_data[1] = 8'($urandom);
                s_last[1] = 1'($urandom);
            end
            cycle();
        end
        s_valid[1] = 1'b0;
        r0[1] = 1'b1;
        r1[1] = 1'b1;
        repeat (6) cycle();
        chk("stress_drained", 1, q[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
